// File: rtl/frame_sync_mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_ctrl_pkg
// Shared definitions for frame_sync_mode_ctrl:
//   fsm_state_t - control FSM states (IDLE, PENDING, APPLY)
//   K_NEXT/K_PREV/K_UP/K_DN - KEY bit index of each button function
//   hex7seg()   - 4-bit value to active-low 7-segment pattern, bit 7 = DP (off)
// -----------------------------------------------------------------------------
package frame_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      APPLY   = 2'd2
   } fsm_state_t;

   localparam int unsigned K_NEXT = 0;
   localparam int unsigned K_PREV = 1;
   localparam int unsigned K_UP   = 2;
   localparam int unsigned K_DN   = 3;

   // Segment order {dp, g, f, e, d, c, b, a}, all active-low
   function automatic logic [7:0] hex7seg(input logic [3:0] v);
      logic [7:0] seg;
      case (v)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/frame_sync_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// frame_sync_mode_ctrl_if
// Active configuration bus from frame_sync_mode_ctrl to the pixel chain.
//   mode       - active mode select (3 bits)
//   level      - active brightness level (4 bits)
//   cfg_update - one-cycle pulse in the cycle mode/level change
//   pending    - shadow configuration differs from active
// Modports: master (driver, the controller), slave (consumer).
// -----------------------------------------------------------------------------
interface frame_sync_mode_ctrl_if;

   logic [2:0] mode;
   logic [3:0] level;
   logic       cfg_update;
   logic       pending;

   modport master (
      output mode,
      output level,
      output cfg_update,
      output pending
   );

   modport slave (
      input mode,
      input level,
      input cfg_update,
      input pending
   );

endinterface

// File: rtl/frame_sync_mode_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, stability-counter debounce and press detector for one
// active-low push button.
//   clk_i    - system clock
//   rst_n_i  - asynchronous active-low reset
//   key_i    - raw asynchronous button level (0 = pressed)
//   level_o  - debounced level (1 = released)
//   press_o  - one-cycle pulse on a debounced 1->0 transition
// Parameter DEBOUNCE_CYCLES: consecutive differing samples needed to accept a
// new level.
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic key_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter only advances while the synced sample disagrees with the
   // accepted level; any agreement restarts the count.
   always_comb begin
      deb_d   = deb_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d   = ~deb_q;
            press_d = deb_q;   // flipping from released to pressed
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign level_o = deb_q;
   assign press_o = press_q;

endmodule

// File: rtl/frame_sync_mode_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_mode_ctrl
// Push-button configuration controller. KEY presses edit shadow mode/level
// registers; the shadow is copied to the active outputs only at a frame
// boundary (falling VGA_VS) or after VS_TIMEOUT cycles without one. SW[0]
// holds off any apply.
//
// Ports:
//   CLOCK_50  - 50 MHz system clock
//   RESET_N   - asynchronous active-low reset
//   KEY[3:0]  - raw buttons, active-low (0 next, 1 prev, 2 up, 3 down)
//   SW[9:0]   - switches; SW[0] = apply hold, rest unused
//   VGA_VS    - vertical sync, active-low, foreign clock domain
//   cfg_bus   - master side of frame_sync_mode_ctrl_if
//               (mode, level, cfg_update, pending)
//   HEX0/HEX1 - mode / level digit, active-low segments
//
// Build option: define MODE_HEX_EN to drive HEX0/HEX1 from a registered
// hex decoder; otherwise both are blank (8'hFF).
// -----------------------------------------------------------------------------
module frame_sync_mode_ctrl
   import frame_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned VS_TIMEOUT      = 2000000,
   parameter int unsigned LEVEL_MAX       = 15,
   parameter int unsigned LEVEL_RST       = 8
) (
   input  logic                          CLOCK_50,
   input  logic                          RESET_N,
   input  logic [3:0]                    KEY,
   input  logic [9:0]                    SW,
   input  logic                          VGA_VS,
   frame_sync_mode_ctrl_if.master        cfg_bus,
   output logic [7:0]                    HEX0,
   output logic [7:0]                    HEX1
);

   localparam int unsigned TW = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(VS_TIMEOUT - 1);
   localparam logic [3:0]    LVL_MAX  = 4'(LEVEL_MAX);
   localparam logic [3:0]    LVL_RST  = 4'(LEVEL_RST);

   // ---------------------------------------------------------------- keys
   logic [3:0] press;
   logic [3:0] key_level_unused;

   for (genvar g = 0; g < 4; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk_i   (CLOCK_50),
         .rst_n_i (RESET_N),
         .key_i   (KEY[g]),
         .level_o (key_level_unused[g]),
         .press_o (press[g])
      );
   end

   logic sw_unused;
   assign sw_unused = ^SW[9:1];

   // ------------------------------------------------- SW[0] / VS sync
   logic sw1_q, sw2_q;
   logic vs1_q, vs2_q, vs3_q;
   logic vs_fall_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sw1_q     <= 1'b0;
         sw2_q     <= 1'b0;
         vs1_q     <= 1'b1;
         vs2_q     <= 1'b1;
         vs3_q     <= 1'b1;
         vs_fall_q <= 1'b0;
      end else begin
         sw1_q     <= SW[0];
         sw2_q     <= sw1_q;
         vs1_q     <= VGA_VS;
         vs2_q     <= vs1_q;
         vs3_q     <= vs2_q;
         // Registered so the FSM sees the edge 3 cycles after the pin
         vs_fall_q <= vs3_q & ~vs2_q;
      end
   end

   // -------------------------------------------------------- shadow edits
   logic [2:0] sh_mode_q,  sh_mode_d;
   logic [3:0] sh_level_q, sh_level_d;

   always_comb begin
      sh_mode_d  = sh_mode_q;
      sh_level_d = sh_level_q;
      // Opposing presses in the same cycle cancel
      if (press[K_NEXT] && !press[K_PREV]) begin
         sh_mode_d = sh_mode_q + 3'd1;
      end else if (press[K_PREV] && !press[K_NEXT]) begin
         sh_mode_d = sh_mode_q - 3'd1;
      end
      if (press[K_UP] && !press[K_DN]) begin
         if (sh_level_q < LVL_MAX) begin
            sh_level_d = sh_level_q + 4'd1;
         end
      end else if (press[K_DN] && !press[K_UP]) begin
         if (sh_level_q != 4'd0) begin
            sh_level_d = sh_level_q - 4'd1;
         end
      end
   end

   // ----------------------------------------------------------------- FSM
   fsm_state_t state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    act_mode_q,  act_mode_d;
   logic [3:0]    act_level_q, act_level_d;
   logic          differs;

   assign differs = (sh_mode_q != act_mode_q) || (sh_level_q != act_level_q);

   // The active registers are loaded on the PENDING->APPLY edge so that the
   // APPLY cycle already presents the new values together with cfg_update.
   // Shadow is sampled from its registered value, so a press in the vs_fall
   // cycle stays in shadow for the next boundary.
   always_comb begin
      state_d     = state_q;
      tmo_d       = '0;
      act_mode_d  = act_mode_q;
      act_level_d = act_level_q;
      case (state_q)
         IDLE: begin
            if (differs) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (!differs) begin
               state_d = IDLE;
            end else if ((vs_fall_q || (tmo_q == TMO_LAST)) && !sw2_q) begin
               state_d     = APPLY;
               act_mode_d  = sh_mode_q;
               act_level_d = sh_level_q;
            end else if (tmo_q == TMO_LAST) begin
               tmo_d = tmo_q;   // saturate while held by SW[0]
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         APPLY: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         tmo_q       <= '0;
         act_mode_q  <= 3'd0;
         act_level_q <= LVL_RST;
         sh_mode_q   <= 3'd0;
         sh_level_q  <= LVL_RST;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         act_mode_q  <= act_mode_d;
         act_level_q <= act_level_d;
         sh_mode_q   <= sh_mode_d;
         sh_level_q  <= sh_level_d;
      end
   end

   assign cfg_bus.mode       = act_mode_q;
   assign cfg_bus.level      = act_level_q;
   assign cfg_bus.cfg_update = (state_q == APPLY);
   assign cfg_bus.pending    = (state_q == PENDING);

   // ------------------------------------------------------------- display
`ifdef MODE_HEX_EN
   logic [7:0] hex0_q, hex1_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         hex0_q <= 8'hFF;
         hex1_q <= 8'hFF;
      end else begin
         hex0_q <= hex7seg({1'b0, act_mode_q});
         hex1_q <= hex7seg(act_level_q);
      end
   end

   assign HEX0 = hex0_q;
   assign HEX1 = hex1_q;
`else
   assign HEX0 = 8'hFF;
   assign HEX1 = 8'hFF;
`endif

endmodule

// File: tb/tb_frame_sync_mode_ctrl.sv
module tb_frame_sync_mode_ctrl;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic       VGA_VS;
   logic [7:0] HEX0, HEX1;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference: active and shadow configuration
   int act_mode, act_level, sh_mode, sh_level;

   frame_sync_mode_ctrl_if cfg_if ();

   frame_sync_mode_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .VS_TIMEOUT      (64),
      .LEVEL_MAX       (15),
      .LEVEL_RST       (8)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .KEY      (KEY),
      .SW       (SW),
      .VGA_VS   (VGA_VS),
      .cfg_bus  (cfg_if),
      .HEX0     (HEX0),
      .HEX1     (HEX1)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] seg_of(input int v);
      logic [7:0] tbl [16];
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return tbl[v];
   endfunction

   task automatic model_reset();
      act_mode = 0; act_level = 8; sh_mode = 0; sh_level = 8;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0; KEY = 4'hF; SW = '0; VGA_VS = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1 RESET_N = 1'b1;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
   endtask

   // Press the keys in mask together, release, then check outputs vs model
   task automatic press_mask(input logic [3:0] mask, input string name);
      logic exp_pend;
      @(posedge CLOCK_50); #1 KEY = ~mask;
      repeat (7) @(posedge CLOCK_50);
      #1 KEY = 4'hF;
      repeat (7) @(posedge CLOCK_50);
      #1;
      if (mask[0] && !mask[1]) sh_mode = (sh_mode + 1) % 8;
      if (mask[1] && !mask[0]) sh_mode = (sh_mode + 7) % 8;
      if (mask[2] && !mask[3] && sh_level < 15) sh_level++;
      if (mask[3] && !mask[2] && sh_level > 0)  sh_level--;
      exp_pend = (sh_mode != act_mode) || (sh_level != act_level);
      checks++;
      if (cfg_if.pending !== exp_pend || cfg_if.mode !== 3'(act_mode) ||
          cfg_if.level !== 4'(act_level) || cfg_if.cfg_update !== 1'b0) begin
         errors++;
         $display("FAIL %s press %b: pend=%b mode=%0d level=%0d upd=%b, required pend=%b mode=%0d level=%0d upd=0",
                  name, mask, cfg_if.pending, cfg_if.mode, cfg_if.level, cfg_if.cfg_update,
                  exp_pend, act_mode, act_level);
      end
   endtask

   // Drop VGA_VS and check the apply window: new values exactly 4 cycles later
   task automatic vs_check(input string name);
      logic exp_upd;
      int   old_mode, old_level, nupd, em, el;
      exp_upd   = (sh_mode != act_mode) || (sh_level != act_level);
      old_mode  = act_mode;
      old_level = act_level;
      nupd      = 0;
      @(posedge CLOCK_50); #1 VGA_VS = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge CLOCK_50); #1;
         if (cfg_if.cfg_update === 1'b1) nupd++;
         if (i == 3) begin
            checks++;
            if (cfg_if.mode !== 3'(old_mode) || cfg_if.level !== 4'(old_level) ||
                cfg_if.cfg_update !== 1'b0) begin
               errors++;
               $display("FAIL %s early: mode=%0d level=%0d upd=%b, required mode=%0d level=%0d upd=0",
                        name, cfg_if.mode, cfg_if.level, cfg_if.cfg_update, old_mode, old_level);
            end
         end
         if (i == 4) begin
            em = exp_upd ? sh_mode  : old_mode;
            el = exp_upd ? sh_level : old_level;
            checks++;
            if (cfg_if.mode !== 3'(em) || cfg_if.level !== 4'(el) ||
                cfg_if.cfg_update !== exp_upd) begin
               errors++;
               $display("FAIL %s apply: mode=%0d level=%0d upd=%b, required mode=%0d level=%0d upd=%b",
                        name, cfg_if.mode, cfg_if.level, cfg_if.cfg_update, em, el, exp_upd);
            end
         end
      end
      checks++;
      if (nupd != (exp_upd ? 1 : 0)) begin
         errors++;
         $display("FAIL %s pulse count: got %0d, required %0d", name, nupd, exp_upd ? 1 : 0);
      end
      act_mode  = sh_mode;
      act_level = sh_level;
      VGA_VS = 1'b1;
      repeat (4) @(posedge CLOCK_50);
      #1;
      checks++;
      if (cfg_if.pending !== 1'b0 || cfg_if.mode !== 3'(act_mode) || cfg_if.level !== 4'(act_level)) begin
         errors++;
         $display("FAIL %s after: pend=%b mode=%0d level=%0d, required pend=0 mode=%0d level=%0d",
                  name, cfg_if.pending, cfg_if.mode, cfg_if.level, act_mode, act_level);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; KEY = 4'hF; SW = '0; VGA_VS = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      #1;
      checks++;
      if (cfg_if.mode !== 3'd0 || cfg_if.level !== 4'd8 || cfg_if.cfg_update !== 1'b0 ||
          cfg_if.pending !== 1'b0 || HEX0 !== 8'hFF || HEX1 !== 8'hFF) begin
         errors++;
         $display("FAIL reset: mode=%0d level=%0d upd=%b pend=%b hex=%h/%h, required 0 8 0 0 ff/ff",
                  cfg_if.mode, cfg_if.level, cfg_if.cfg_update, cfg_if.pending, HEX0, HEX1);
      end
      do_reset();
   endtask

   task automatic test_basic_apply();
      do_reset();
      press_mask(4'b0001, "basic_next");
      vs_check("basic_vs");
   endtask

   task automatic test_mode_wrap();
      do_reset();
      press_mask(4'b0010, "wrap_prev");
      vs_check("wrap_vs");
   endtask

   task automatic test_level_sat();
      do_reset();
      for (int i = 0; i < 4; i++) press_mask(4'b0100, "sat_up_a");
      vs_check("sat_vs_a");
      for (int i = 0; i < 3; i++) press_mask(4'b0100, "sat_up_b");
      vs_check("sat_vs_b");
      press_mask(4'b0100, "sat_up_extra");
      checks++;
      if (cfg_if.level !== 4'd15 || cfg_if.pending !== 1'b0) begin
         errors++;
         $display("FAIL sat_ceiling: level=%0d pend=%b, required level=15 pend=0",
                  cfg_if.level, cfg_if.pending);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      @(posedge CLOCK_50); #1 KEY[0] = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1 KEY[0] = 1'b1;
      repeat (10) @(posedge CLOCK_50);
      #1;
      checks++;
      if (cfg_if.pending !== 1'b0) begin
         errors++;
         $display("FAIL glitch_pending: got %b, required 0", cfg_if.pending);
      end
      vs_check("glitch_vs");
   endtask

   task automatic test_cancel();
      do_reset();
      press_mask(4'b0001, "cancel_next");
      press_mask(4'b0010, "cancel_prev");
      vs_check("cancel_vs");
   endtask

   task automatic test_sw_hold();
      int nupd, wait_cyc;
      logic seen;
      do_reset();
      SW[0] = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      press_mask(4'b1000, "hold_dn");
      nupd = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLOCK_50); #1;
         if (cfg_if.cfg_update === 1'b1 || cfg_if.level !== 4'd8) nupd++;
      end
      checks++;
      if (nupd != 0 || cfg_if.pending !== 1'b1) begin
         errors++;
         $display("FAIL hold_no_apply: bad cycles=%0d pend=%b, required 0 and pend=1", nupd, cfg_if.pending);
      end
      SW[0] = 1'b0;
      seen = 1'b0;
      wait_cyc = 0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(posedge CLOCK_50); #1;
         if (cfg_if.cfg_update === 1'b1) begin
            seen = 1'b1;
            wait_cyc = i;
         end
      end
      checks++;
      if (!seen || wait_cyc > 3 || cfg_if.level !== 4'd7) begin
         errors++;
         $display("FAIL hold_release: seen=%b after %0d cycles level=%0d, required seen=1 within 3 level=7",
                  seen, wait_cyc, cfg_if.level);
      end
      act_level = sh_level;
   endtask

   task automatic test_hex();
      logic [7:0] e0, e1;
      do_reset();
      for (int i = 0; i < 3; i++) press_mask(4'b0001, "hex_next");
      vs_check("hex_vs");
      repeat (2) @(posedge CLOCK_50);
      #1;
`ifdef MODE_HEX_EN
      e0 = seg_of(act_mode);
      e1 = seg_of(act_level);
`else
      e0 = 8'hFF;
      e1 = 8'hFF;
`endif
      checks++;
      if (HEX0 !== e0 || HEX1 !== e1) begin
         errors++;
         $display("FAIL hex: HEX0=%h HEX1=%h, required %h %h", HEX0, HEX1, e0, e1);
      end
   endtask

   task automatic test_reset_mid_pending();
      do_reset();
      press_mask(4'b0101, "rstmid_press");
      #3 RESET_N = 1'b0;
      #1;
      checks++;
      if (cfg_if.pending !== 1'b0 || cfg_if.mode !== 3'd0 || cfg_if.level !== 4'd8) begin
         errors++;
         $display("FAIL reset_mid_pending: pend=%b mode=%0d level=%0d, required 0 0 8",
                  cfg_if.pending, cfg_if.mode, cfg_if.level);
      end
      @(posedge CLOCK_50); #1 RESET_N = 1'b1;
      model_reset();
      vs_check("rstmid_vs");
   endtask

   task automatic test_random();
      int n;
      logic [3:0] mask;
      do_reset();
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            mask = 4'($urandom_range(1, 15));
            press_mask(mask, "rand_press");
         end
         vs_check("rand_vs");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_apply();
      test_mode_wrap();
      test_level_sat();
      test_glitch();
      test_cancel();
      test_sw_hold();
      test_hex();
      test_reset_mid_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
